// File: rtl/fetch_stream_ctrl_if.sv
// Fetch-stream bus: IF-stage redirect/consume, decode window, and icache request port.
interface fetch_stream_ctrl_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        consume_i;
    logic        consume_len_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] head_pc_o;
    logic        err_o;
    logic [2:0]  avail_o;
    logic        req_o;
    logic [31:0] req_addr_o;
    logic        gnt_i;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        rsp_err_i;

    modport slave (
        input  redirect_i, redirect_pc_i, consume_i, consume_len_i,
               gnt_i, rsp_valid_i, rsp_data_i, rsp_err_i,
        output valid_o, instr_o, head_pc_o, err_o, avail_o, req_o, req_addr_o
    );

    modport master (
        output redirect_i, redirect_pc_i, consume_i, consume_len_i,
               gnt_i, rsp_valid_i, rsp_data_i, rsp_err_i,
        input  valid_o, instr_o, head_pc_o, err_o, avail_o, req_o, req_addr_o
    );
endinterface

// File: rtl/fetch_stream_ctrl.sv
// Fetch request sequencer feeding a halfword prefetch queue; tracks credit,
// outstanding requests and stale responses, and presents a 32-bit decode window.
module fetch_stream_ctrl #(
    parameter int DEPTH     = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_stream_ctrl_if.slave bus
);
    localparam int QN = 2 * DEPTH;
    localparam int CW = $clog2(QN + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

    typedef struct packed {
        logic        err;
        logic [15:0] hw;
    } hw_t;

    state_e           state_q, state_d;
    hw_t [QN-1:0]     q_q, q_d;
    logic [CW-1:0]    avail_q, avail_d;
    logic [OW-1:0]    outst_q, outst_d;
    logic [OW-1:0]    drop_q, drop_d;
    logic             skip_q, skip_d;
    logic [31:0]      head_pc_q, head_pc_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;

    logic             has1, has2, valid;
    logic             req_raw, gnt_acc, rsp_acc, rsp_keep, pop_ok;
    logic [CW-1:0]    n_pop, mid;
    hw_t              lo_e, hi_e;

    // Decode window is purely a function of the queue registers.
    always_comb begin
        has1  = avail_q >= CW'(1);
        has2  = avail_q >= CW'(2);
        valid = 1'b0;
        if (has1 && q_q[0].err)                 valid = 1'b1;
        else if (has1 && q_q[0].hw[1:0] != 2'b11) valid = 1'b1;
        else if (has2)                          valid = 1'b1;
    end

    assign bus.valid_o    = valid;
    assign bus.err_o      = has1 && q_q[0].err;
    assign bus.instr_o    = {has2 ? q_q[1].hw : 16'h0, has1 ? q_q[0].hw : 16'h0};
    assign bus.head_pc_o  = head_pc_q;
    assign bus.avail_o    = 3'(avail_q);
    assign bus.req_o      = req_raw && !bus.redirect_i;
    assign bus.req_addr_o = fetch_addr_q;

    always_comb begin
        state_d      = state_q;
        q_d          = q_q;
        avail_d      = avail_q;
        outst_d      = outst_q;
        drop_d       = drop_q;
        skip_d       = skip_q;
        head_pc_d    = head_pc_q;
        fetch_addr_d = fetch_addr_q;
        lo_e         = '{err: bus.rsp_err_i, hw: bus.rsp_data_i[15:0]};
        hi_e         = '{err: bus.rsp_err_i, hw: bus.rsp_data_i[31:16]};

        // Credit reserves two halfwords per in-flight word, ignoring same-cycle pops.
        req_raw  = (state_q == RUN) && (int'(outst_q) < MAX_OUTST) &&
                   (int'(avail_q) + 2 * int'(outst_q) + 2 <= QN);
        gnt_acc  = req_raw && bus.gnt_i;
        rsp_acc  = bus.rsp_valid_i && (outst_q != '0);
        rsp_keep = rsp_acc && (drop_q == '0) && !bus.redirect_i;
        pop_ok   = bus.consume_i && valid && !bus.redirect_i;

        n_pop = '0;
        if (pop_ok) n_pop = (bus.consume_len_i && has2) ? CW'(2) : CW'(1);

        outst_d = outst_q + OW'(gnt_acc) - OW'(rsp_acc);
        if (gnt_acc) fetch_addr_d = fetch_addr_q + 32'd4;
        if (rsp_acc && drop_q != '0) drop_d = drop_q - OW'(1);

        for (int i = 0; i < QN; i++) begin
            q_d[i] = '0;
            for (int j = 0; j < QN; j++)
                if (j == i + int'(n_pop)) q_d[i] = q_q[j];
        end
        mid     = avail_q - n_pop;
        avail_d = mid;

        if (rsp_keep) begin
            if (skip_q) begin
                for (int i = 0; i < QN; i++)
                    if (i == int'(mid)) q_d[i] = hi_e;
                avail_d = mid + CW'(1);
                skip_d  = 1'b0;
            end else begin
                for (int i = 0; i < QN; i++) begin
                    if (i == int'(mid))     q_d[i] = lo_e;
                    if (i == int'(mid) + 1) q_d[i] = hi_e;
                end
                avail_d = mid + CW'(2);
            end
            if (bus.rsp_err_i && state_q == RUN) state_d = HALT;
        end

        if (pop_ok) head_pc_d = head_pc_q + (bus.consume_len_i ? 32'd4 : 32'd2);

        if (bus.redirect_i) begin
            state_d      = RUN;
            q_d          = '0;
            avail_d      = '0;
            head_pc_d    = {bus.redirect_pc_i[31:1], 1'b0};
            fetch_addr_d = {bus.redirect_pc_i[31:2], 2'b00};
            skip_d       = bus.redirect_pc_i[1];
            // Everything still in flight after this cycle belongs to the old stream.
            drop_d       = outst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            q_q          <= '0;
            avail_q      <= '0;
            outst_q      <= '0;
            drop_q       <= '0;
            skip_q       <= 1'b0;
            head_pc_q    <= '0;
            fetch_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            avail_q      <= avail_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            skip_q       <= skip_d;
            head_pc_q    <= head_pc_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end
endmodule
